// File: rtl/dmem_arbiter_if.sv
// Bundle of requester-side and dmem-side signals for dmem_arbiter.
// slave = arbiter side; master = requesters plus the memory that answers them.
interface dmem_arbiter_if #(
  parameter int NUM_REQ = 2,
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32
);
  logic [NUM_REQ-1:0]        i_req;
  logic [NUM_REQ-1:0]        i_wren;
  logic [NUM_REQ*ADDR_W-1:0] i_addr;
  logic [NUM_REQ*DATA_W-1:0] i_wdata;
  logic [NUM_REQ-1:0]        o_gnt;
  logic [NUM_REQ-1:0]        o_rvalid;
  logic [DATA_W-1:0]         o_rdata;
  logic [NUM_REQ-1:0]        o_busy;
  logic [ADDR_W-1:0]         o_mem_addr;
  logic [DATA_W-1:0]         o_mem_wdata;
  logic                      o_mem_wren;
  logic [DATA_W-1:0]         i_mem_rdata;

  modport slave (
    input  i_req, i_wren, i_addr, i_wdata, i_mem_rdata,
    output o_gnt, o_rvalid, o_rdata, o_busy, o_mem_addr, o_mem_wdata, o_mem_wren
  );

  modport master (
    output i_req, i_wren, i_addr, i_wdata, i_mem_rdata,
    input  o_gnt, o_rvalid, o_rdata, o_busy, o_mem_addr, o_mem_wdata, o_mem_wren
  );
endinterface

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing one single-port synchronous dmem among NUM_REQ requesters.
// Define DMEM_ARB_PRIO0_EN to give requester 0 absolute priority over the round-robin group.
module dmem_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32
) (
  input  logic           i_clk,
  input  logic           i_reset,
  dmem_arbiter_if.slave  bus
);
  localparam int SEL_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [SEL_W:0]   NUM_REQ_W = (SEL_W+1)'(NUM_REQ);
  localparam logic [SEL_W-1:0] LAST_IDX  = SEL_W'(NUM_REQ - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  state_t state_reg, state_next;
  logic [SEL_W-1:0]  sel_reg, sel_next;
  logic [SEL_W-1:0]  rr_ptr_reg, rr_ptr_next;
  logic [ADDR_W-1:0] mem_addr_reg;
  logic [DATA_W-1:0] mem_wdata_reg;

  logic [ADDR_W-1:0] addr_arr  [NUM_REQ];
  logic [DATA_W-1:0] wdata_arr [NUM_REQ];
  logic [NUM_REQ-1:0] gnt;
  logic [NUM_REQ-1:0] rvalid;
  logic [NUM_REQ-1:0] done;
  logic [NUM_REQ-1:0] cand;
  logic               win_found;
  logic [SEL_W-1:0]   win_idx;
  logic               sel_wren;
  logic [SEL_W:0]     scan_sum;
  logic [SEL_W-1:0]   scan_idx;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_slice
      assign addr_arr[gi]  = bus.i_addr[gi*ADDR_W +: ADDR_W];
      assign wdata_arr[gi] = bus.i_wdata[gi*DATA_W +: DATA_W];
      // A write finishes on its grant cycle, a read on its rvalid cycle.
      assign done[gi]      = (gnt[gi] & bus.i_wren[gi]) | rvalid[gi];
    end
  endgenerate

  assign sel_wren = bus.i_wren[sel_reg];

  // Winner = first candidate at or after rr_ptr, wrapping; scanning downward
  // lets the lowest offset overwrite any earlier hit.
  always_comb begin
    cand = bus.i_req;
`ifdef DMEM_ARB_PRIO0_EN
    cand[0] = 1'b0;
`endif
    win_found = 1'b0;
    win_idx   = '0;
    scan_sum  = '0;
    scan_idx  = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      scan_sum = {1'b0, rr_ptr_reg} + (SEL_W+1)'(i);
      if (scan_sum >= NUM_REQ_W) begin
        scan_sum = scan_sum - NUM_REQ_W;
      end
      scan_idx = scan_sum[SEL_W-1:0];
      if (cand[scan_idx]) begin
        win_found = 1'b1;
        win_idx   = scan_idx;
      end
    end
`ifdef DMEM_ARB_PRIO0_EN
    if (bus.i_req[0]) begin
      win_found = 1'b1;
      win_idx   = '0;
    end
`endif
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state_reg     <= IDLE;
      sel_reg       <= '0;
      rr_ptr_reg    <= '0;
      mem_addr_reg  <= '0;
      mem_wdata_reg <= '0;
    end else begin
      state_reg  <= state_next;
      sel_reg    <= sel_next;
      rr_ptr_reg <= rr_ptr_next;
      if (state_reg == ACCESS) begin
        mem_addr_reg  <= addr_arr[sel_reg];
        mem_wdata_reg <= wdata_arr[sel_reg];
      end
    end
  end

  always_comb begin
    state_next  = state_reg;
    sel_next    = sel_reg;
    rr_ptr_next = rr_ptr_reg;
    case (state_reg)
      IDLE: begin
        if (win_found) begin
          sel_next   = win_idx;
          state_next = ACCESS;
        end
      end
      ACCESS: begin
        rr_ptr_next = (sel_reg == LAST_IDX) ? '0 : sel_reg + SEL_W'(1);
`ifdef DMEM_ARB_PRIO0_EN
        if (sel_reg == '0) begin
          rr_ptr_next = rr_ptr_reg;
        end
`endif
        state_next = sel_wren ? IDLE : RESP;
      end
      RESP: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Memory address/data hold their last driven value outside ACCESS.
  always_comb begin
    gnt             = '0;
    rvalid          = '0;
    bus.o_mem_wren  = 1'b0;
    bus.o_mem_addr  = mem_addr_reg;
    bus.o_mem_wdata = mem_wdata_reg;
    bus.o_rdata     = '0;
    case (state_reg)
      ACCESS: begin
        gnt[sel_reg]    = 1'b1;
        bus.o_mem_wren  = sel_wren;
        bus.o_mem_addr  = addr_arr[sel_reg];
        bus.o_mem_wdata = wdata_arr[sel_reg];
      end
      RESP: begin
        rvalid[sel_reg] = 1'b1;
        bus.o_rdata     = bus.i_mem_rdata;
      end
      default: begin
      end
    endcase
  end

  assign bus.o_gnt    = gnt;
  assign bus.o_rvalid = rvalid;
  assign bus.o_busy   = bus.i_req & ~done;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed scoreboard bench for dmem_arbiter (NUM_REQ=4) with a behavioural dmem.
// Expected sequences follow the DMEM_ARB_PRIO0_EN setting of the build.
module tb_dmem_arbiter;
  localparam int N = 4;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  dmem_arbiter_if #(.NUM_REQ(N), .ADDR_W(32), .DATA_W(32)) bus();

  dmem_arbiter #(.NUM_REQ(N), .ADDR_W(32), .DATA_W(32)) dut (
    .i_clk   (clk),
    .i_reset (rst_n),
    .bus     (bus)
  );

  // Single-port synchronous memory; contents reload while reset is held.
  logic [31:0] mem [0:63];
  always @(posedge clk) begin
    if (!rst_n) begin
      for (int w = 0; w < 64; w++) mem[w] <= 32'h5A00_0000 + 32'(w) * 32'h0101;
      mem[4] <= 32'hDEAD_BEEF;
    end else if (bus.o_mem_wren) begin
      mem[bus.o_mem_addr[7:2]] <= bus.o_mem_wdata;
    end
    bus.i_mem_rdata <= mem[bus.o_mem_addr[7:2]];
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    bit          is_rv;
    int          cyc;
    logic [N-1:0] oh;
    logic [31:0] addr;
    bit          wr;
    logic [31:0] data;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int failures = 0;
  int done_cnt = 0;
  int done_target = 0;
  int tnext = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=0x%08h required=0x%08h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic push_gnt(input int k, input bit wr, input logic [31:0] a, input logic [31:0] d);
    exp_t e;
    e.is_rv = 1'b0; e.cyc = tnext + 1; e.oh = N'(1) << k;
    e.addr = a; e.wr = wr; e.data = d;
    sb.push_back(e);
  endtask

  // One complete access: grant one cycle after issue, read data one cycle later.
  task automatic exp_acc(input int k, input bit wr, input logic [31:0] a, input logic [31:0] d);
    exp_t e;
    push_gnt(k, wr, a, d);
    if (!wr) begin
      e = sb[$];
      e.is_rv = 1'b1; e.cyc = tnext + 2;
      sb.push_back(e);
      tnext += 3;
    end else begin
      tnext += 2;
    end
    done_target++;
  endtask

  task automatic drive(input logic [N-1:0] req, input logic [N-1:0] wr);
    @(posedge clk); #1;
    bus.i_req  = req;
    bus.i_wren = wr;
    tnext = cyc;
  endtask

  task automatic set_addr(input int k, input logic [31:0] a);
    bus.i_addr[k*32 +: 32] = a;
  endtask

  task automatic set_wdata(input int k, input logic [31:0] d);
    bus.i_wdata[k*32 +: 32] = d;
  endtask

  task automatic wait_done();
    int budget = 60;
    while (done_cnt < done_target && budget > 0) begin
      @(negedge clk); #1;
      budget--;
    end
    if (done_cnt < done_target) begin
      checks++;
      failures++;
      $display("FAIL completion_timeout done=%0d required=%0d (cycle %0d)", done_cnt, done_target, cyc);
      done_cnt = done_target;
      sb.delete();
    end
  endtask

  // Monitor: pops one expectation per grant/rvalid cycle, checks busy every cycle.
  always @(negedge clk) begin
    logic [N-1:0] pulse;
    exp_t e;
    pulse = '0;
    if (|bus.o_gnt || |bus.o_rvalid) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_output gnt=%b rvalid=%b required=none (cycle %0d)", bus.o_gnt, bus.o_rvalid, cyc);
      end else begin
        e = sb.pop_front();
        chk("event_cycle", cyc, e.cyc);
        if (!e.is_rv) begin
          chk("gnt", 32'(bus.o_gnt), 32'(e.oh));
          chk("rvalid_in_access", 32'(bus.o_rvalid), 32'd0);
          chk("mem_addr", bus.o_mem_addr, e.addr);
          chk("mem_wren", 32'(bus.o_mem_wren), 32'(e.wr));
          if (e.wr) begin
            chk("mem_wdata", bus.o_mem_wdata, e.data);
            pulse = e.oh;
            done_cnt++;
          end
        end else begin
          chk("rvalid", 32'(bus.o_rvalid), 32'(e.oh));
          chk("gnt_in_resp", 32'(bus.o_gnt), 32'd0);
          chk("rdata", bus.o_rdata, e.data);
          chk("wren_in_resp", 32'(bus.o_mem_wren), 32'd0);
          chk("mem_addr_hold", bus.o_mem_addr, e.addr);
          pulse = e.oh;
          done_cnt++;
        end
      end
    end else begin
      chk("idle_wren", 32'(bus.o_mem_wren), 32'd0);
    end
    chk("busy", 32'(bus.o_busy), 32'(bus.i_req & ~pulse));
  end

  initial begin
    #200000;
    $display("FAIL global_timeout (cycle %0d)", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0;
    bus.i_req   = '0;
    bus.i_wren  = '0;
    bus.i_addr  = '0;
    bus.i_wdata = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_gnt", 32'(bus.o_gnt), 32'd0);
    chk("rst_rvalid", 32'(bus.o_rvalid), 32'd0);
    chk("rst_wren", 32'(bus.o_mem_wren), 32'd0);
    chk("rst_mem_addr", bus.o_mem_addr, 32'd0);
    chk("rst_mem_wdata", bus.o_mem_wdata, 32'd0);
    chk("rst_rdata", bus.o_rdata, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Single read from requester 0.
    drive(4'b0001, 4'b0000);
    set_addr(0, 32'h10);
    exp_acc(0, 1'b0, 32'h10, 32'hDEAD_BEEF);
    wait_done();

    // Single write from requester 1.
    drive(4'b0010, 4'b0010);
    set_addr(1, 32'h20);
    set_wdata(1, 32'h1234_5678);
    exp_acc(1, 1'b1, 32'h20, 32'h1234_5678);
    wait_done();

    // Read back the written word through requester 2.
    drive(4'b0100, 4'b0000);
    set_addr(2, 32'h20);
    exp_acc(2, 1'b0, 32'h20, 32'h1234_5678);
    wait_done();

    // Contention between requesters 0 and 1, then requester 0 releases.
    drive(4'b0011, 4'b0000);
    set_addr(0, 32'h14);
    set_addr(1, 32'h18);
`ifdef DMEM_ARB_PRIO0_EN
    for (int i = 0; i < 4; i++) exp_acc(0, 1'b0, 32'h14, 32'h5A00_0505);
`else
    for (int i = 0; i < 2; i++) begin
      exp_acc(0, 1'b0, 32'h14, 32'h5A00_0505);
      exp_acc(1, 1'b0, 32'h18, 32'h5A00_0606);
    end
`endif
    wait_done();
    drive(4'b0010, 4'b0000);
    exp_acc(1, 1'b0, 32'h18, 32'h5A00_0606);
    wait_done();

    // Wrap-around: requester 3 then requester 0.
    drive(4'b1001, 4'b0000);
    set_addr(3, 32'h30);
`ifdef DMEM_ARB_PRIO0_EN
    exp_acc(0, 1'b0, 32'h14, 32'h5A00_0505);
    exp_acc(0, 1'b0, 32'h14, 32'h5A00_0505);
`else
    exp_acc(3, 1'b0, 32'h30, 32'h5A00_0C0C);
    exp_acc(0, 1'b0, 32'h14, 32'h5A00_0505);
`endif
    wait_done();

    // Reset during RESP of a read: grant seen, no rvalid.
    drive(4'b0001, 4'b0000);
    set_addr(0, 32'h10);
    push_gnt(0, 1'b0, 32'h10, 32'hDEAD_BEEF);
    @(posedge clk);
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_rvalid", 32'(bus.o_rvalid), 32'd0);
    chk("midrst_gnt", 32'(bus.o_gnt), 32'd0);
    chk("midrst_rdata", bus.o_rdata, 32'd0);
    chk("midrst_mem_addr", bus.o_mem_addr, 32'd0);
    @(posedge clk);
    @(posedge clk); #1;
    rst_n = 1'b1;
    bus.i_req = 4'b0011;
    tnext = cyc;
`ifdef DMEM_ARB_PRIO0_EN
    exp_acc(0, 1'b0, 32'h10, 32'hDEAD_BEEF);
    exp_acc(0, 1'b0, 32'h10, 32'hDEAD_BEEF);
`else
    exp_acc(0, 1'b0, 32'h10, 32'hDEAD_BEEF);
    exp_acc(1, 1'b0, 32'h18, 32'h5A00_0606);
`endif
    wait_done();

    drive(4'b0000, 4'b0000);
    repeat (4) @(negedge clk);
    #1;
    chk("queue_empty", 32'(sb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
